mdio_master_param: RTL
======================

Name: mdio_master_param

Overview:
- Parametrised MDIO management master; successor to the fixed Clause-22 controller.
- Serialises one 32-bit management frame from T_DATA onto MDC/MDIO after a configurable preamble.
- Supports Clause 22 (ST=01) and Clause 45 (ST=00) frames, with a configurable MDC divider.
- Sits between the host register interface and the external PHY tri-state MDIO pad (pad buffer lives outside).

Parameters:
- CLK_DIV, 2, clk cycles per MDC half-period (>=1); MDC period = 2*CLK_DIV clk.
- PRE_LEN, 32, preamble ones before frame (0..32; 0 = preamble suppression).
- CNT_W, 6, width of bit counter (must hold PRE_LEN and 32).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- MDIO_START  in  1  start request, sampled only in IDLE
- T_DATA  in  32  frame: [31:30] ST, [29:28] OP, [27:23] PHYAD/PRTAD, [22:18] REGAD/DEVAD, [17:16] TA, [15:0] data
- MDIO_IN  in  1  MDIO pad input
- RD_DATA  out  16  last read data, MSB first
- DATA_RDY  out  1  one-cycle completion pulse (read and write)
- BUSY  out  1  transaction in progress
- ERR  out  1  turnaround error flag (see Optional Feature)
- MDC  out  1  management clock
- MDIO_OE  out  1  pad output enable
- MDIO_OUT  out  1  pad output data

Behaviour:
- Reset (async, any time incl. mid-frame): state IDLE, MDC=0, MDIO_OE=0, MDIO_OUT=0, BUSY=0, DATA_RDY=0, ERR=0, RD_DATA=16'h0000, divider and bit counter = 0.
- Read detect: OP[1]==1 (C22 read 10; C45 read 11 / post-read-inc 10). Otherwise write/address, full 32 bits driven.
- States: IDLE -> PRE (PRE_LEN bits, skipped if 0) -> HDR (bits 31..18, 14 bits) -> read: TA (2 bits, OE=0) -> RDAT (16 bits, OE=0); write: WDAT (bits 17..0, 18 bits) -> DONE -> IDLE.
- Start: MDIO_START=1 in IDLE latches T_DATA. Next cycle BUSY=1, MDIO_OE=1, MDC=0, MDIO_OUT = first bit.
- MDIO_START while BUSY: ignored. T_DATA changes after the latch have no effect.
- MDC: low for CLK_DIV clk, then high for CLK_DIV clk, per bit. Held low in IDLE.
- MDIO_OUT changes only on the clk edge where MDC goes high->low (bit boundary).
- MDIO_IN is registered on the clk edge where MDC goes low->high. RDAT shifts MSB first.
- Completion: DATA_RDY pulses exactly 1 + (PRE_LEN+32)*2*CLK_DIV cycles after the START sample edge.
  - In that same cycle BUSY falls, MDC=0 and MDIO_OE=0.
  - On a read, RD_DATA updates in the DATA_RDY cycle and holds until the next read completes. Writes never modify RD_DATA.
- Back-to-back: MDIO_START asserted in the DATA_RDY cycle is ignored. It is accepted from the following cycle.

Optional Feature:
- MDIO_TA_CHECK_EN defined:
  - On reads, MDIO_IN sampled in the second TA bit must be 0.
  - If it is 1, the frame still completes; RD_DATA = 16'hFFFF; ERR=1 in the DATA_RDY cycle.
  - ERR is sticky until the next accepted MDIO_START.
- Not defined: ERR tied 0 and no TA sampling.

Decomposition:
- Package mdio_pkg holds:
  - Field bit positions (ST, OP, PHYAD, REGAD, TA, DATA).
  - Opcode constants (C22_RD=2'b10, C22_WR=2'b01, C45_ADDR=2'b00, C45_WR=2'b01, C45_RD=2'b11, C45_PRIA=2'b10) and ST constants (C22=2'b01, C45=2'b00).
  - State encodings.
- Sub-module mdc_clkgen (parameter CLK_DIV):
  - Inputs: clk, rst, enable.
  - Outputs: MDC plus one-cycle rise/fall strobes.
  - FSM and shift/counter logic stay in the top.

Test Plan:
- Write, CLK_DIV=2, PRE_LEN=32, T_DATA=32'h5A3C_BEEF -> 32 ones then bits of 5A3CBEEF MSB first on MDIO_OUT with OE=1 throughout; DATA_RDY at cycle 257; RD_DATA stays 0.
- Read, T_DATA=32'h6A3C_0000, PHY model drives TA=Z/0 then 16'hC0DE -> OE=0 for the last 18 bits; RD_DATA=16'hC0DE on the DATA_RDY pulse; ERR=0.
- PRE_LEN=0, CLK_DIV=1, C45 address frame 32'h0A3E_1234 -> no preamble; DATA_RDY 65 cycles after start; MDC period 2 clk.
- MDIO_START pulsed at bit 10 of an active frame, and also in the DATA_RDY cycle -> both ignored; a single DATA_RDY; the next start is accepted one cycle later.
- rst asserted mid-RDAT -> outputs return to reset values asynchronously; the next read completes normally with the correct data.
- MDIO_TA_CHECK_EN: PHY drives 1 in the second TA bit -> RD_DATA=16'hFFFF, ERR=1; ERR clears on the next MDIO_START.

Source files
------------

// File: rtl/mdio_pkg.sv
// Shared frame layout, opcode/ST encodings and FSM states for the MDIO master.
package mdio_pkg;

  typedef enum logic [1:0] {ST_C45 = 2'b00, ST_C22 = 2'b01} mdio_st_e;
  typedef enum logic [1:0] {C22_WR = 2'b01, C22_RD = 2'b10} mdio_c22_op_e;
  typedef enum logic [1:0] {
    C45_ADDR = 2'b00, C45_WR = 2'b01, C45_PRIA = 2'b10, C45_RD = 2'b11
  } mdio_c45_op_e;

  // Field positions of the 32-bit management frame, MSB first on the wire.
  typedef struct packed {
    logic [1:0]  st;
    logic [1:0]  op;
    logic [4:0]  phyad;
    logic [4:0]  regad;
    logic [1:0]  ta;
    logic [15:0] data;
  } mdio_frame_t;

  localparam int HDR_BITS  = 14;
  localparam int TA_BITS   = 2;
  localparam int DATA_BITS = 16;
  localparam int WDAT_BITS = 18;

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_HDR, S_TA, S_RDAT, S_WDAT, S_DONE
  } mdio_state_e;

endpackage

// File: rtl/mdc_clkgen.sv
// MDC generator: CLK_DIV clk low then CLK_DIV clk high per bit, held low while disabled.
// Strobes flag the clk edge at which MDC will rise or fall.
module mdc_clkgen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic mdc,
  output logic mdc_rise,
  output logic mdc_fall
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic          mdc_q, mdc_d;
  logic          tick;

  assign tick = enable && (div_q == LAST);

  always_comb begin
    div_d = div_q;
    mdc_d = mdc_q;
    if (!enable) begin
      div_d = '0;
      mdc_d = 1'b0;
    end else if (tick) begin
      div_d = '0;
      mdc_d = ~mdc_q;
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
      mdc_q <= 1'b0;
    end else begin
      div_q <= div_d;
      mdc_q <= mdc_d;
    end
  end

  assign mdc      = mdc_q;
  assign mdc_rise = tick & ~mdc_q;
  assign mdc_fall = tick & mdc_q;

endmodule

// File: rtl/mdio_master_param.sv
// MDIO management master: optional preamble then one 32-bit Clause 22/45 frame on MDC/MDIO.
// Define MDIO_TA_CHECK_EN to flag reads where the PHY fails to drive 0 in the second TA bit.
module mdio_master_param #(
  parameter int CLK_DIV = 2,
  parameter int PRE_LEN = 32,
  parameter int CNT_W   = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MDIO_START,
  input  logic [31:0] T_DATA,
  input  logic        MDIO_IN,
  output logic [15:0] RD_DATA,
  output logic        DATA_RDY,
  output logic        BUSY,
  output logic        ERR,
  output logic        MDC,
  output logic        MDIO_OE,
  output logic        MDIO_OUT
);
  import mdio_pkg::*;

  localparam logic [CNT_W-1:0] PRE_LAST  = (PRE_LEN > 0) ? CNT_W'(PRE_LEN - 1) : '0;
  localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(HDR_BITS - 1);
  localparam logic [CNT_W-1:0] TA_LAST   = CNT_W'(TA_BITS - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] WDAT_LAST = CNT_W'(WDAT_BITS - 1);

  mdio_state_e      state_q;
  mdio_frame_t      frame_in;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      sh_q;
  logic [15:0]      rx_q, rd_data_q;
  logic             rd_q, run_q, busy_q, oe_q, out_q, rdy_q;
  logic             mdc_rise, mdc_fall, accept, ta_bad;

  assign frame_in = T_DATA;
  // A start seen in the completion-pulse cycle is dropped.
  assign accept   = (state_q == S_IDLE) && MDIO_START && !rdy_q;

  mdc_clkgen #(.CLK_DIV(CLK_DIV)) u_mdc (
    .clk(clk), .rst(rst), .enable(run_q),
    .mdc(MDC), .mdc_rise(mdc_rise), .mdc_fall(mdc_fall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      sh_q      <= '0;
      rx_q      <= '0;
      rd_data_q <= '0;
      rd_q      <= 1'b0;
      run_q     <= 1'b0;
      busy_q    <= 1'b0;
      oe_q      <= 1'b0;
      out_q     <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      if (mdc_rise && state_q == S_RDAT) rx_q <= {rx_q[14:0], MDIO_IN};
      case (state_q)
        S_IDLE: if (accept) begin
          busy_q <= 1'b1;
          oe_q   <= 1'b1;
          run_q  <= 1'b1;
          rd_q   <= frame_in.op[1];
          if (PRE_LEN > 0) begin
            state_q <= S_PRE;
            cnt_q   <= PRE_LAST;
            out_q   <= 1'b1;
            sh_q    <= frame_in;
          end else begin
            state_q <= S_HDR;
            cnt_q   <= HDR_LAST;
            out_q   <= frame_in[31];
            sh_q    <= {frame_in[30:0], 1'b0};
          end
        end
        S_PRE: if (mdc_fall) begin
          if (cnt_q == '0) begin
            state_q <= S_HDR;
            cnt_q   <= HDR_LAST;
            out_q   <= sh_q[31];
            sh_q    <= {sh_q[30:0], 1'b0};
          end else cnt_q <= cnt_q - 1'b1;
        end
        S_HDR: if (mdc_fall) begin
          if (cnt_q == '0 && rd_q) begin
            state_q <= S_TA;
            cnt_q   <= TA_LAST;
            oe_q    <= 1'b0;
            out_q   <= 1'b0;
          end else begin
            if (cnt_q == '0) begin
              state_q <= S_WDAT;
              cnt_q   <= WDAT_LAST;
            end else cnt_q <= cnt_q - 1'b1;
            out_q <= sh_q[31];
            sh_q  <= {sh_q[30:0], 1'b0};
          end
        end
        S_TA: if (mdc_fall) begin
          if (cnt_q == '0) begin
            state_q <= S_RDAT;
            cnt_q   <= DATA_LAST;
          end else cnt_q <= cnt_q - 1'b1;
        end
        S_RDAT: if (mdc_fall) begin
          if (cnt_q == '0) begin
            state_q <= S_DONE;
            run_q   <= 1'b0;
          end else cnt_q <= cnt_q - 1'b1;
        end
        S_WDAT: if (mdc_fall) begin
          if (cnt_q == '0) begin
            state_q <= S_DONE;
            run_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
            out_q <= sh_q[31];
            sh_q  <= {sh_q[30:0], 1'b0};
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          oe_q    <= 1'b0;
          out_q   <= 1'b0;
          rdy_q   <= 1'b1;
          if (rd_q) rd_data_q <= ta_bad ? 16'hFFFF : rx_q;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef MDIO_TA_CHECK_EN
  logic ta_err_q, err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ta_err_q <= 1'b0;
      err_q    <= 1'b0;
    end else if (accept) begin
      ta_err_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (state_q == S_TA && mdc_rise && cnt_q == '0) ta_err_q <= MDIO_IN;
      if (state_q == S_DONE) err_q <= ta_err_q;
    end
  end

  assign ta_bad = ta_err_q;
  assign ERR    = err_q;
`else
  assign ta_bad = 1'b0;
  assign ERR    = 1'b0;
`endif

  assign RD_DATA  = rd_data_q;
  assign DATA_RDY = rdy_q;
  assign BUSY     = busy_q;
  assign MDIO_OE  = oe_q;
  assign MDIO_OUT = out_q;

endmodule
